input_debouncer: RTL

Conditioning stage that sits directly upstream of the registered capture stage (`D_FLIPFLOP`-style `d` input). It takes a raw asynchronous level, such as a push-button, switch or off-chip strobe, and synchronises it into the `clk` domain. It filters out pulses shorter than a programmable stability window and presents a clean level `dout`, plus single-cycle edge pulses, for the downstream register to consume.

---
 rtl/input_debouncer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Synchronises a raw asynchronous level into the clk domain, rejects pulses
// shorter than STABLE_CYCLES cycles and presents a clean registered level plus
// single-cycle edge pulses for a downstream capture register.
//
// Parameters:
//   SYNC_STAGES   - synchroniser depth (>= 2)
//   STABLE_CYCLES - cycles of sustained disagreement before dout follows
//                   (1 .. 2**CNT_W-1)
//   CNT_W         - stability counter width
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   asynchronous, active-low; clears all state immediately
//   din    in   raw asynchronous level
//   enable in   1 = filtering active; 0 = hold dout, clear counter
//   dout   out  debounced, registered level
//   rise   out  one-cycle pulse in the cycle dout becomes 1
//   fall   out  one-cycle pulse in the cycle dout becomes 0
//   busy   out  combinational: synchronised input differs from dout
// -----------------------------------------------------------------------------
module input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic enable,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  // Illegal parameter sets stop elaboration rather than building a counter
  // that could wrap before reaching its terminal value.
  if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 ||
      longint'(STABLE_CYCLES) > ((longint'(1) << CNT_W) - longint'(1))) begin : g_param_check
    $fatal(1, "input_debouncer: illegal SYNC_STAGES/STABLE_CYCLES/CNT_W combination");
  end

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  // Terminal count: the edge that sees this value with the mismatch still
  // present is the commit edge.
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_out;
  logic                   w_mismatch;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_count;
  logic                   r_dout;
  logic                   r_rise;
  logic                   r_fall;

  // Synchroniser runs regardless of enable; nothing else looks at din.
  // NOTE: every flop here, including the synchroniser, is cleared by the
  // asynchronous reset so a reset mid-window discards any pending change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking assignment so each stage takes the previous
      // stage's value from before this edge, giving a true shift chain.
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_mismatch = (w_sync_out != r_dout);

  // The edge that enters CHECK already counts as the first disagreeing
  // cycle, so a change is committed on the STABLE_CYCLES-th consecutive
  // enabled edge that sees the mismatch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_STABLE;
      r_count <= '0;
      r_dout  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_STABLE: begin
          r_count <= '0;
          if (enable && w_mismatch) begin
            if (STABLE_CYCLES == 1) begin
              r_dout <= w_sync_out;
              r_rise <= w_sync_out;
              r_fall <= ~w_sync_out;
            end else begin
              r_state <= ST_CHECK;
              r_count <= CNT_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (!enable || !w_mismatch) begin
            // Losing enable or agreement throws the partial window away.
            r_state <= ST_STABLE;
            r_count <= '0;
          end else if (r_count == LP_LAST) begin
            r_state <= ST_STABLE;
            r_count <= '0;
            r_dout  <= w_sync_out;
            r_rise  <= w_sync_out;
            r_fall  <= ~w_sync_out;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_STABLE;
          r_count <= '0;
        end
      endcase
    end
  end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = w_mismatch;

endmodule
